// File: rtl/mdu_ctrl_pkg.sv
// Shared multiply/divide definitions: MD op encodings, HI/LO funct codes and controller state type.
// The D-stage decoder uses the same constants to produce md_use_D/start/op.
package mdu_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  // True for any R-type funct that touches HI/LO (drives md_use_D in decode).
  function automatic logic is_md_funct(input logic [5:0] funct);
    return funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                         FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  // Ops that occupy the arithmetic unit (as opposed to MTHI/MTLO or no-ops).
  function automatic logic is_arith_op(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath on the latched operands.
// Divide truncates toward zero; remainder takes the dividend's sign.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic        is_div;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  always_comb begin
    is_div    = (op == MD_DIV) || (op == MD_DIVU);
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];

    // Low 64 bits of the product of sign/zero-extended operands give both MULT and MULTU.
    a_ext = {{32{a_neg}}, a};
    b_ext = {{32{b_neg}}, b};
    prod  = a_ext * b_ext;

    // Magnitude divide; 0x80000000 negates to itself, which yields the wrapped quotient.
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    div0   = is_div & (b == 32'd0);
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    res_hi = is_div ? rem  : prod[63:32];
    res_lo = is_div ? quot : prod[31:0];
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer with HI/LO registers and D-stage stall request.
// Operands are latched at issue; HI/LO update only on the last busy cycle.
//
//   state  | meaning
//   S_IDLE | ready; MTHI/MTLO write directly, MULT*/DIV* latch operands
//   S_MUL  | multiply in flight, cnt counts down from MUL_CYCLES
//   S_DIV  | divide in flight, cnt counts down from DIV_CYCLES
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_div0;

  mdu_arith u_arith (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .res_hi (arith_hi),
    .res_lo (arith_lo),
    .div0   (arith_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              a_d     = rs_val;
              b_d     = rt_val;
              op_d    = op;
              cnt_d   = MUL_LOAD;
              state_d = S_MUL;
            end
            MD_DIV, MD_DIVU: begin
              a_d     = rs_val;
              b_d     = rt_val;
              op_d    = op;
              cnt_d   = DIV_LOAD;
              state_d = S_DIV;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        // Starts arriving while busy fall through here and are dropped.
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!arith_div0) begin
            hi_d = arith_hi;
            lo_d = arith_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign stall_md = md_use_D & (busy | (start & is_arith_op(op)));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: latency, arithmetic results, MTHI/MTLO,
// divide-by-zero, stall generation, ignored starts and asynchronous reset.
module tb_mdu_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_ctrl #(
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    start  = 1'b0;
    op     = OP_NOP;
    rs_val = 32'hDEAD_BEEF;
    rt_val = 32'h0BAD_F00D;
  endtask

  // Drives an issue on the next negedge (cycle 0 of the operation).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d);
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    md_use_D = use_d;
  endtask

  // Issues one arithmetic op and checks busy window, held HI/LO, and final result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh, input logic [31:0] el,
                        input string name);
    logic [31:0] oh, ol;
    issue(o, a, b, 1'b0);
    oh = hi;
    ol = lo;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s issue cycle busy: got %b expected 0", name, busy);
    end
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++;
      if (busy !== 1'b1 || hi !== oh || lo !== ol) begin
        n_fail++;
        $display("FAIL %s cycle %0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                 name, c, busy, hi, lo, oh, ol);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== eh || lo !== el) begin
      n_fail++;
      $display("FAIL %s result: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
               name, busy, hi, lo, eh, el);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    md_use_D = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h expected all 0",
               busy, stall_md, hi, lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg2x3");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_N, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, MUL_N, 32'hC000_0000, 32'h8000_0000, "mult_maxmin");
    run_op(OP_MULTU, 32'h7FFF_FFFF, 32'h8000_0000, MUL_N, 32'h3FFF_FFFF, 32'h8000_0000, "multu_maxmin");
  endtask

  task automatic test_div();
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0000_0000, 32'h8000_0000, "div_overflow");
    run_op(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, DIV_N, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2");
    run_op(OP_DIVU, 32'h0000_0064, 32'h0000_0007, DIV_N, 32'h0000_0002, 32'h0000_000E, "divu_100by7");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, DIV_N, 32'h0000_000F, 32'h0FFF_FFFF, "divu_maxby16");
  endtask

  task automatic test_mthi_mtlo_div0();
    issue(OP_MTHI, 32'h0000_0011, 32'h0000_0000, 1'b0);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_busy: got %b expected 0", busy);
    end
    issue(OP_MTLO, 32'h0000_0022, 32'h0000_0000, 1'b0);
    #1;
    n_checks++;
    if (hi !== 32'h11 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_value: hi=%h busy=%b expected hi=00000011 busy=0", hi, busy);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (lo !== 32'h22 || hi !== 32'h11 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mtlo_value: hi=%h lo=%h busy=%b expected hi=00000011 lo=00000022 busy=0",
               hi, lo, busy);
    end
    run_op(OP_DIVU, 32'h0000_0005, 32'h0000_0000, DIV_N, 32'h0000_0011, 32'h0000_0022, "divu_by0");
    run_op(OP_DIV,  32'hFFFF_FFF0, 32'h0000_0000, DIV_N, 32'h0000_0011, 32'h0000_0022, "div_by0");
  endtask

  task automatic test_stall_ignore();
    issue(OP_MULTU, 32'h0000_0007, 32'h0000_0006, 1'b1);
    #1;
    n_checks++;
    if (stall_md !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_issue: got %b expected 1", stall_md);
    end
    for (int c = 1; c <= MUL_N; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b1;
        op     = OP_DIV;
        rs_val = 32'd100;
        rt_val = 32'd3;
      end else begin
        idle_inputs();
      end
      #1;
      n_checks++;
      if (stall_md !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_busy cycle %0d: stall=%b busy=%b expected 1 1", c, stall_md, busy);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (stall_md !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
      n_fail++;
      $display("FAIL stall_done: stall=%b busy=%b hi=%h lo=%h expected 0 0 00000000 0000002a",
               stall_md, busy, hi, lo);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || lo !== 32'd42) begin
      n_fail++;
      $display("FAIL ignored_start: busy=%b lo=%h expected busy=0 lo=0000002a", busy, lo);
    end

    issue(OP_DIV, 32'h0000_0009, 32'h0000_0002, 1'b0);
    for (int c = 0; c <= DIV_N + 1; c++) begin
      if (c > 0) begin
        @(negedge clk);
        idle_inputs();
      end
      #1;
      n_checks++;
      if (stall_md !== 1'b0) begin
        n_fail++;
        $display("FAIL nostall cycle %0d: stall=%b expected 0", c, stall_md);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd4) begin
      n_fail++;
      $display("FAIL nostall_result: busy=%b hi=%h lo=%h expected 0 00000001 00000004",
               busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(OP_MULT, 32'h0000_0005, 32'h0000_0007, 1'b0);
    repeat (3) begin
      @(negedge clk);
      idle_inputs();
    end
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle: busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
      end
    end
    run_op(OP_MULT, 32'h0000_0002, 32'h0000_0003, MUL_N, 32'h0000_0000, 32'h0000_0006, "mult_after_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo_div0();
    test_stall_ignore();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide controller with HI/LO registers for the 5-stage pipeline. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per cycle from the E stage and sequences the arithmetic over a fixed latency. Drives a stall request so the hazard unit can freeze F/D while a D-stage HI/LO instruction cannot proceed.

Parameters:
MUL_CYCLES, 5, busy duration in cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  E-stage instruction is a valid MD op this cycle
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others no-op
rs_val  input  32  forwarded rs operand (E stage, post forward-mux)
rt_val  input  32  forwarded rt operand (E stage, post forward-mux)
md_use_D  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
busy  output  1  arithmetic in progress
stall_md  output  1  stall request to the pipeline stall unit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, cnt=0, busy=0, hi=0, lo=0, latched operands=0. Any in-flight result is discarded.
- States: IDLE, MUL, DIV. A 4-bit (or wider, sized to max parameter) down-counter cnt.
- IDLE, start=1, op in {0,1}: latch rs/rt and signedness, cnt<=MUL_CYCLES, go MUL.
- IDLE, start=1, op in {2,3}: same latch, cnt<=DIV_CYCLES, go DIV.
- IDLE, start=1, op=4/5: hi<=rs_val (MTHI) or lo<=rs_val (MTLO) at that edge. State stays IDLE and busy stays 0.
- IDLE, start=1, op in 6..7: ignored.
- MUL/DIV: cnt decrements each cycle. On the edge where cnt==1, write hi/lo, go IDLE, cnt<=0.
- Latency: start in cycle 0, then busy=1 in cycles 1..N (N=MUL_CYCLES or DIV_CYCLES). New hi/lo and busy=0 are visible in cycle N+1. hi/lo keep their old values throughout cycles 1..N.
- start while busy is ignored; operands and result are unaffected. The pipeline stall prevents this in normal operation.
- busy = (state != IDLE), driven from registers.
- stall_md = md_use_D & (busy | (start & op<=3)). This is combinational and holds for the whole busy window, including the issue cycle.
- MULT: signed 32x32 -> 64; hi=product[63:32], lo=product[31:0]. MULTU is the unsigned equivalent.
- DIV: signed, truncated toward zero. lo=quotient; hi=remainder, sign of dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned.
- Divisor 0 (DIV/DIVU): full busy duration still elapses; hi and lo are left unchanged.
- Results are computed from the latched operands only. Later changes on rs_val/rt_val have no effect.

Decomposition:
- Shared define header (existing opcode/funct include): MD op encodings 0..5 and the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO funct codes. The decoder producing md_use_D/start/op reuses these.
- One sub-module, mdu_arith: purely combinational. Inputs are the latched a, b, op; outputs are res_hi, res_lo, div0. Selected by mdu_ctrl on completion.
- FSM, counter and HI/LO registers stay in mdu_ctrl.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 at cycle 0 -> busy=1 in cycles 1..5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy=1 for exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (busy stays 0, values visible the next cycle), then DIVU rt=0 -> 10 busy cycles, hi=0x11, lo=0x22 unchanged.
- Stall and ignore: md_use_D=1 in the issue cycle and during busy -> stall_md=1 in cycles 0..N, 0 in cycle N+1. A second start during busy is ignored and the result matches the first op only. md_use_D=0 -> stall_md=0 throughout.
- Reset asserted asynchronously mid-MULT (cycle 3, between edges) -> busy, hi and lo go to 0 immediately. After release, a fresh MULT 2*3 gives lo=6 after 5 cycles.
